power_emu_bus_master: RTL and testbench



---
 rtl/power_emu_pkg.sv | 25 ++
 rtl/power_emu_bus_master_if.sv | 33 +++
 rtl/power_emu_cmd_fifo.sv | 48 ++++
 rtl/power_emu_bus_master.sv | 101 ++++++++++
 tb/tb_power_emu_bus_master.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/power_emu_pkg.sv
// Shared types and constants for the power-emulator register bus master.
package power_emu_pkg;
  localparam int PE_ADDR_W      = 3;
  localparam int PE_DATA_W      = 32;
  localparam int PE_WR_MAX_ADDR = 3;
  localparam int PE_RD_MIN_ADDR = 5;

  typedef enum logic [2:0] {
    ST_IDLE, ST_WRITE, ST_READ, ST_WAIT, ST_RESP
  } pe_state_e;

  typedef struct packed {
    logic                 write;
    logic [PE_ADDR_W-1:0] addr;
    logic [PE_DATA_W-1:0] wdata;
  } pe_cmd_t;

  localparam int PE_CMD_W = $bits(pe_cmd_t);

  // The slave silently drops out-of-window accesses, so the master screens them.
  function automatic logic pe_cmd_legal(pe_cmd_t c, logic [PE_ADDR_W-1:0] wr_max,
                                        logic [PE_ADDR_W-1:0] rd_min);
    return c.write ? (c.addr <= wr_max) : (c.addr >= rd_min);
  endfunction
endpackage

// File: rtl/power_emu_bus_master_if.sv
// Host command/response stream plus register bus, seen from the master side.
interface power_emu_bus_master_if;
  import power_emu_pkg::*;

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic                 cmd_write;
  logic [PE_ADDR_W-1:0] cmd_addr;
  logic [PE_DATA_W-1:0] cmd_wdata;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [PE_DATA_W-1:0] rsp_data;
  logic                 rsp_err;
  logic                 rsp_write;
  logic                 m_read;
  logic                 m_write;
  logic [PE_ADDR_W-1:0] m_addr;
  logic [PE_DATA_W-1:0] m_wdata;
  logic [PE_DATA_W-1:0] m_rdata;
  logic                 busy;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, m_rdata,
    output cmd_ready, rsp_valid, rsp_data, rsp_err, rsp_write,
           m_read, m_write, m_addr, m_wdata, busy
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, m_rdata,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err, rsp_write,
           m_read, m_write, m_addr, m_wdata, busy
  );
endinterface

// File: rtl/power_emu_cmd_fifo.sv
// Count-based synchronous command FIFO; head entry is visible combinationally.
module power_emu_cmd_fifo
  import power_emu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  pe_cmd_t din,
  input  logic    pop,
  output pe_cmd_t dout,
  output logic    full,
  output logic    empty
);
  localparam int AW = $clog2(DEPTH);

  pe_cmd_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/power_emu_bus_master.sv
// Buffers host commands and runs each as one in-order register bus cycle.
module power_emu_bus_master
  import power_emu_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int RD_LATENCY  = 1,
  parameter int WR_MAX_ADDR = PE_WR_MAX_ADDR,
  parameter int RD_MIN_ADDR = PE_RD_MIN_ADDR
) (
  input  logic                   clk,
  input  logic                   reset,
  power_emu_bus_master_if.master bus
);
  localparam logic [PE_ADDR_W-1:0] WR_MAX = PE_ADDR_W'(WR_MAX_ADDR);
  localparam logic [PE_ADDR_W-1:0] RD_MIN = PE_ADDR_W'(RD_MIN_ADDR);

  pe_state_e            state, state_nxt;
  pe_cmd_t              head, fifo_din;
  logic                 fifo_full, fifo_empty, fifo_pop;
  logic                 head_legal;
  logic                 err_q, write_q;
  logic [2:0]           lat_cnt;
  logic [PE_ADDR_W-1:0] m_addr_q;
  logic [PE_DATA_W-1:0] m_wdata_q, rsp_data_q;

  assign fifo_din = '{write: bus.cmd_write, addr: bus.cmd_addr, wdata: bus.cmd_wdata};

  power_emu_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (bus.cmd_valid),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_legal = pe_cmd_legal(head, WR_MAX, RD_MIN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Rejected commands borrow the WRITE slot with the strobe masked, so their
  // response appears on the same edge a write response would.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (!fifo_empty) state_nxt = (head_legal && !head.write) ? ST_READ : ST_WRITE;
      ST_WRITE: state_nxt = ST_RESP;
      ST_READ:  state_nxt = ST_WAIT;
      ST_WAIT:  if (lat_cnt <= 3'd1) state_nxt = ST_RESP;
      ST_RESP:  if (bus.rsp_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    fifo_pop      = (state == ST_IDLE) && !fifo_empty;
    bus.m_write   = (state == ST_WRITE) && !err_q;
    bus.m_read    = (state == ST_READ);
    bus.rsp_valid = (state == ST_RESP);
    bus.busy      = !fifo_empty || (state != ST_IDLE);
    bus.cmd_ready = !fifo_full;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q      <= 1'b0;
      write_q    <= 1'b0;
      lat_cnt    <= '0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      rsp_data_q <= '0;
    end else begin
      if (fifo_pop) begin
        err_q      <= !head_legal;
        write_q    <= head.write;
        rsp_data_q <= '0;
        // Bus address/data only move for commands that will strobe.
        if (head_legal) begin
          m_addr_q <= head.addr;
          if (head.write) m_wdata_q <= head.wdata;
        end
      end
      if (state == ST_READ) lat_cnt <= 3'(RD_LATENCY);
      if (state == ST_WAIT) begin
        lat_cnt <= lat_cnt - 1'b1;
        if (lat_cnt <= 3'd1) rsp_data_q <= bus.m_rdata;
      end
    end
  end

  assign bus.m_addr    = m_addr_q;
  assign bus.m_wdata   = m_wdata_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = err_q;
  assign bus.rsp_write = write_q;
endmodule

// File: tb/tb_power_emu_bus_master.sv
// Directed bench for power_emu_bus_master with a one-cycle-latency slave model.
module tb_power_emu_bus_master;
  import power_emu_pkg::*;

  localparam int RD_LAT = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  power_emu_bus_master_if bus();

  power_emu_bus_master #(
    .FIFO_DEPTH(4), .RD_LATENCY(RD_LAT), .WR_MAX_ADDR(3), .RD_MIN_ADDR(5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk = 0, n_pass = 0;
  int wr_cnt = 0, rd_cnt = 0, both_cnt = 0;
  logic [31:0] rq_data[$];
  logic        rq_err[$];
  logic        rq_write[$];

  function automatic logic [31:0] mem_val(logic [2:0] a);
    return {8{{1'b0, a}}};
  endfunction

  // Slave returns data one edge after the strobe and noise otherwise, so a
  // capture on the wrong edge shows up as a data error.
  always @(posedge clk) bus.m_rdata <= bus.m_read ? mem_val(bus.m_addr) : $urandom;

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.m_write) wr_cnt <= wr_cnt + 1;
      if (bus.m_read)  rd_cnt <= rd_cnt + 1;
      if (bus.m_read && bus.m_write) both_cnt <= both_cnt + 1;
      if (bus.rsp_valid && bus.rsp_ready) begin
        rq_data.push_back(bus.rsp_data);
        rq_err.push_back(bus.rsp_err);
        rq_write.push_back(bus.rsp_write);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic push(input logic w, input logic [2:0] a, input logic [31:0] d);
    int i;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    i = 0;
    while (!bus.cmd_ready && i < 100) begin
      @(negedge clk);
      i++;
    end
    if (!bus.cmd_ready) chk("push_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic clear_q();
    rq_data.delete();
    rq_err.delete();
    rq_write.delete();
  endtask

  task automatic wait_rsp(input int n);
    for (int i = 0; i < 200 && rq_data.size() < n; i++) @(negedge clk);
    @(negedge clk);
    chk("rsp_cnt", rq_data.size(), n);
  endtask

  logic [31:0] e4_data [5] = '{32'h0, 32'h55555555, 32'h0, 32'h66666666, 32'h77777777};
  logic        e4_wr   [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    int w0, r0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b1;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_strobes", {bus.m_read, bus.m_write}, 2'b00);
    chk("rst_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_write}, 3'b000);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_addr", bus.m_addr, 3'd0);
    chk("rst_wdata", bus.m_wdata, 32'h0);
    chk("rst_rdata", bus.rsp_data, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", bus.cmd_ready, 1'b1);

    // legal write
    clear_q();
    push(1'b1, 3'd2, 32'h12345678);
    @(negedge clk);
    chk("t1_wr_e0", bus.m_write, 1'b0);
    chk("t1_busy", bus.busy, 1'b1);
    @(negedge clk);
    chk("t1_wr_e1", bus.m_write, 1'b1);
    chk("t1_addr", bus.m_addr, 3'd2);
    chk("t1_wdata", bus.m_wdata, 32'h12345678);
    chk("t1_rv_e1", bus.rsp_valid, 1'b0);
    @(negedge clk);
    chk("t1_wr_e2", bus.m_write, 1'b0);
    chk("t1_rsp_e2", {bus.rsp_valid, bus.rsp_err, bus.rsp_write}, 3'b101);
    chk("t1_rdata", bus.rsp_data, 32'h0);
    wait_rsp(1);
    chk("t1_wr_cnt", wr_cnt, 1);

    // legal read
    clear_q();
    push(1'b0, 3'd6, 32'h0);
    @(negedge clk);
    chk("t2_rd_e0", bus.m_read, 1'b0);
    @(negedge clk);
    chk("t2_rd_e1", {bus.m_read, bus.m_write}, 2'b10);
    chk("t2_addr", bus.m_addr, 3'd6);
    @(negedge clk);
    chk("t2_rd_e2", bus.m_read, 1'b0);
    chk("t2_rv_e2", bus.rsp_valid, 1'b0);
    @(negedge clk);
    chk("t2_rsp_e3", {bus.rsp_valid, bus.rsp_err, bus.rsp_write}, 3'b100);
    chk("t2_rdata", bus.rsp_data, 32'h66666666);
    wait_rsp(1);
    chk("t2_rd_cnt", rd_cnt, 1);

    // out-of-window read then write
    clear_q();
    push(1'b0, 3'd3, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("t3_rv_e1", bus.rsp_valid, 1'b0);
    @(negedge clk);
    chk("t3_rsp_e2", {bus.rsp_valid, bus.rsp_err}, 2'b11);
    push(1'b1, 3'd4, 32'hdeadbeef);
    wait_rsp(2);
    chk("t3_err0", rq_err[0], 1'b1);
    chk("t3_err1", rq_err[1], 1'b1);
    chk("t3_data0", rq_data[0], 32'h0);
    chk("t3_data1", rq_data[1], 32'h0);
    chk("t3_order", {rq_write[0], rq_write[1]}, 2'b01);
    chk("t3_no_wr", wr_cnt, 1);
    chk("t3_no_rd", rd_cnt, 1);
    chk("t3_addr_hold", bus.m_addr, 3'd6);

    // back-pressure fills the FIFO
    clear_q();
    w0 = wr_cnt;
    r0 = rd_cnt;
    bus.rsp_ready = 1'b0;
    push(1'b1, 3'd0, 32'haaaaaaaa);
    push(1'b0, 3'd5, 32'h0);
    push(1'b1, 3'd1, 32'hbbbbbbbb);
    push(1'b0, 3'd6, 32'h0);
    push(1'b0, 3'd7, 32'h0);
    @(negedge clk);
    chk("t4_full", bus.cmd_ready, 1'b0);
    repeat (3) @(negedge clk);
    chk("t4_held", bus.rsp_valid, 1'b1);
    chk("t4_none", rq_data.size(), 0);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("t4_rdy_h0", bus.cmd_ready, 1'b0);
    @(negedge clk);
    chk("t4_rdy_h1", bus.cmd_ready, 1'b1);
    wait_rsp(5);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t4_data%0d", k), rq_data[k], e4_data[k]);
      chk($sformatf("t4_wr%0d", k), rq_write[k], e4_wr[k]);
      chk($sformatf("t4_err%0d", k), rq_err[k], 1'b0);
    end
    chk("t4_wr_cnt", wr_cnt - w0, 2);
    chk("t4_rd_cnt", rd_cnt - r0, 3);

    // response held stable while not accepted
    clear_q();
    bus.rsp_ready = 1'b0;
    push(1'b0, 3'd7, 32'h0);
    for (int i = 0; i < 50 && !bus.rsp_valid; i++) @(negedge clk);
    chk("t5_valid", bus.rsp_valid, 1'b1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t5_hold_flags", {bus.rsp_valid, bus.rsp_err, bus.rsp_write}, 3'b100);
      chk("t5_hold_data", bus.rsp_data, 32'h77777777);
    end
    bus.rsp_ready = 1'b1;
    wait_rsp(1);

    // reset while waiting for read data
    clear_q();
    push(1'b0, 3'd5, 32'h0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("t6_strobes", {bus.m_read, bus.m_write}, 2'b00);
    chk("t6_rv", bus.rsp_valid, 1'b0);
    chk("t6_busy", bus.busy, 1'b0);
    chk("t6_addr", bus.m_addr, 3'd0);
    chk("t6_rdata", bus.rsp_data, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("t6_no_rsp", rq_data.size(), 0);
    chk("t6_idle", {bus.rsp_valid, bus.busy}, 2'b00);
    push(1'b1, 3'd1, 32'hcafef00d);
    @(negedge clk);
    @(negedge clk);
    chk("t6_wr", bus.m_write, 1'b1);
    chk("t6_wdata", bus.m_wdata, 32'hcafef00d);
    wait_rsp(1);
    chk("t6_rsp_wr", rq_write[0], 1'b1);

    chk("both_strobes", both_cnt, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
